// File: rtl/i2s_tx_fifo_ser.sv
// rtl/i2s_tx_fifo_ser.sv - I2S transmit FIFO with master/slave frame serialiser
//
// Purpose: buffers DATA_W-bit samples and shifts them out as I2S (Philips) or
// left-justified frames. Frames are fetched atomically at the left-slot start,
// so stereo words always leave as an L/R pair. A frame with too few queued
// words is sent as zeros and flagged. All logic is in the wclk domain.
//
// Ports:
//   wclk, rst            clock, synchronous active-high reset
//   wen, din             write request and sample word (LSB-aligned to the slot)
//   enable               transmit enable, acted on at frame boundaries
//   master               1 = generate sck_o/ws_o, 0 = follow sck_i/ws_i
//   stereo               1 = L/R word pair per frame, 0 = one word in both slots
//   standard             00 Philips, 01 left-justified, 1x Philips
//   frame_size           0 = DATA_W/2-bit slots, 1 = DATA_W-bit slots
//   sck_i, ws_i          asynchronous slave bit clock and word select
//   underrun_clr         clears the sticky underrun and overflow flags
//   sck_o, ws_o, sd_o    bit clock (master), word select, serial data MSB first
//   full, empty, level   registered FIFO occupancy
//   underrun, overflow   sticky error flags
//   underrun_cnt         saturating zero-filled frame count
//
// Optional feature: define I2S_TX_UNDERRUN_CNT_EN to build the underrun_cnt
// counter; otherwise underrun_cnt is tied to zero.

module i2s_tx_fifo_ser #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 8,
    parameter int CLK_DIV = 4
) (
    input  logic                   wclk,
    input  logic                   rst,
    input  logic                   wen,
    input  logic [DATA_W-1:0]      din,
    input  logic                   enable,
    input  logic                   master,
    input  logic                   stereo,
    input  logic [1:0]             standard,
    input  logic                   frame_size,
    input  logic                   sck_i,
    input  logic                   ws_i,
    input  logic                   underrun_clr,
    output logic                   sck_o,
    output logic                   ws_o,
    output logic                   sd_o,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   underrun,
    output logic                   overflow,
    output logic [15:0]            underrun_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(DATA_W);
    localparam int SW = BW + 1;
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [SW-1:0] S_FULL = SW'(DATA_W);
    localparam logic [SW-1:0] S_HALF = SW'(DATA_W / 2);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t state, state_n;

    // FIFO storage and pointers
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr, rptr, rptr_p1;
    logic [LW-1:0]     level_n;
    logic              wr;
    logic [1:0]        pop_n;

    // Bit clock divider and slave synchronisers
    logic [DW-1:0] div;
    logic          div_tc;
    logic          sck_meta, sck_sync, sck_prev;
    logic          ws_meta, ws_sync, ws_last;
    logic          sck_fall, ws_fall, ws_rise, shift_ev;

    // Serialiser state
    logic              ch, ch_n;
    logic [BW-1:0]     bcnt, bcnt_n;
    logic [DATA_W-1:0] word0, word1, word0_n, word1_n;
    logic              lj_prev;
    logic              cfg_master, cfg_philips, cfg_fs;
    logic              fs_n, philips_n;
    logic [SW-1:0]     s_cur, s_n;
    logic [BW-1:0]     idx;
    logic              last_bit, sd_lj;

    // Control strobes from the FSM
    logic frame_start, force_zero, jump_right, advance, go_idle, upd_out;
    logic fetch_ok, underrun_evt;

    assign wr       = wen && !full;
    assign rptr_p1  = rptr + AW'(1);
    assign level_n  = level + LW'(wr) - LW'(pop_n);
    assign div_tc   = (div == DW'(CLK_DIV - 1));
    assign sck_fall = sck_prev && !sck_sync;
    // ws_last holds ws as seen at the previous slave bit-clock fall, so edges
    // are judged per bit slot rather than per wclk cycle.
    assign ws_fall  = ws_last && !ws_sync;
    assign ws_rise  = !ws_last && ws_sync;
    assign shift_ev = cfg_master ? (div_tc && sck_o) : sck_fall;
    assign s_cur    = cfg_fs ? S_FULL : S_HALF;
    assign last_bit = ({1'b0, bcnt} == s_cur - SW'(1));

    always_ff @(posedge wclk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        frame_start = 1'b0;
        force_zero  = 1'b0;
        jump_right  = 1'b0;
        advance     = 1'b0;
        go_idle     = 1'b0;
        upd_out     = 1'b0;
        case (state)
            IDLE: begin
                if (enable && (master || (sck_fall && ws_fall))) begin
                    frame_start = 1'b1;
                    upd_out     = 1'b1;
                    state_n     = RUN;
                end
            end
            RUN: begin
                if (shift_ev) begin
                    upd_out = 1'b1;
                    if (!cfg_master && ws_fall && !(ch && last_bit)) begin
                        // Left-slot start seen early: realign, zero this frame.
                        frame_start = 1'b1;
                        force_zero  = 1'b1;
                    end else if (!cfg_master && ws_rise && !(!ch && last_bit)) begin
                        jump_right = 1'b1;
                    end else if (ch && last_bit) begin
                        if (enable) begin
                            frame_start = 1'b1;
                        end else begin
                            go_idle = 1'b1;
                            state_n = IDLE;
                        end
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Frame fetch, next bit position and the left-justified data bit.
    // Philips output is this same stream delayed by one shift event.
    always_comb begin
        fetch_ok     = frame_start && !force_zero &&
                       (stereo ? (level >= LW'(2)) : (level != '0));
        pop_n        = fetch_ok ? (stereo ? 2'd2 : 2'd1) : 2'd0;
        underrun_evt = (frame_start && !fetch_ok) || jump_right;
        word0_n      = word0;
        word1_n      = word1;
        ch_n         = ch;
        bcnt_n       = bcnt;
        fs_n         = cfg_fs;
        philips_n    = cfg_philips;
        if (frame_start) begin
            word0_n   = fetch_ok ? mem[rptr] : '0;
            word1_n   = fetch_ok ? (stereo ? mem[rptr_p1] : mem[rptr]) : '0;
            ch_n      = 1'b0;
            bcnt_n    = '0;
            fs_n      = frame_size;
            philips_n = (standard != 2'b01);
        end else if (jump_right) begin
            word1_n = '0;
            ch_n    = 1'b1;
            bcnt_n  = '0;
        end else if (advance) begin
            if (last_bit) begin
                ch_n   = 1'b1;
                bcnt_n = '0;
            end else begin
                bcnt_n = bcnt + BW'(1);
            end
        end else if (go_idle) begin
            ch_n   = 1'b0;
            bcnt_n = '0;
        end
        s_n   = fs_n ? S_FULL : S_HALF;
        idx   = BW'(s_n - SW'(1)) - bcnt_n;
        sd_lj = ch_n ? word1_n[idx] : word0_n[idx];
    end

    always_ff @(posedge wclk) begin
        if (rst) begin
            ch          <= 1'b0;
            bcnt        <= '0;
            word0       <= '0;
            word1       <= '0;
            lj_prev     <= 1'b0;
            sd_o        <= 1'b0;
            ws_o        <= 1'b0;
            cfg_master  <= 1'b0;
            cfg_philips <= 1'b0;
            cfg_fs      <= 1'b0;
        end else begin
            ch    <= ch_n;
            bcnt  <= bcnt_n;
            word0 <= word0_n;
            word1 <= word1_n;
            if (frame_start) begin
                cfg_master  <= master;
                cfg_philips <= philips_n;
                cfg_fs      <= frame_size;
            end
            if (go_idle) begin
                sd_o    <= 1'b0;
                ws_o    <= 1'b0;
                lj_prev <= 1'b0;
            end else if (upd_out) begin
                sd_o    <= philips_n ? lj_prev : sd_lj;
                ws_o    <= ch_n;
                lj_prev <= sd_lj;
            end
        end
    end

    // Divider runs only while transmitting as master; it rests at 0 with
    // sck_o low so the first rise comes a full half-period after start.
    always_ff @(posedge wclk) begin
        if (rst) begin
            div   <= '0;
            sck_o <= 1'b0;
        end else if (state == RUN && cfg_master) begin
            if (div_tc) begin
                div   <= '0;
                sck_o <= ~sck_o;
            end else begin
                div <= div + DW'(1);
            end
        end else begin
            div   <= '0;
            sck_o <= 1'b0;
        end
    end

    always_ff @(posedge wclk) begin
        if (rst) begin
            sck_meta <= 1'b0;
            sck_sync <= 1'b0;
            sck_prev <= 1'b0;
            ws_meta  <= 1'b0;
            ws_sync  <= 1'b0;
            ws_last  <= 1'b0;
        end else begin
            sck_meta <= sck_i;
            sck_sync <= sck_meta;
            sck_prev <= sck_sync;
            ws_meta  <= ws_i;
            ws_sync  <= ws_meta;
            if (sck_fall) begin
                ws_last <= ws_sync;
            end
        end
    end

    always_ff @(posedge wclk) begin
        if (wr) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge wclk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (wr) begin
                wptr <= wptr + AW'(1);
            end
            rptr  <= rptr + AW'(pop_n);
            level <= level_n;
            full  <= (level_n == LW'(DEPTH));
            empty <= (level_n == '0);
        end
    end

    // Sticky flags: a new error in the clearing cycle wins.
    always_ff @(posedge wclk) begin
        if (rst) begin
            overflow <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (wen && full) begin
                overflow <= 1'b1;
            end else if (underrun_clr) begin
                overflow <= 1'b0;
            end
            if (underrun_evt) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
        end
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] ucnt;

    always_ff @(posedge wclk) begin
        if (rst) begin
            ucnt <= '0;
        end else if (underrun_evt && ucnt != 16'hFFFF) begin
            ucnt <= ucnt + 16'd1;
        end
    end

    assign underrun_cnt = ucnt;
`else
    assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_i2s_tx_fifo_ser.sv
// tb/tb_i2s_tx_fifo_ser.sv - self-checking bench for i2s_tx_fifo_ser
module tb_i2s_tx_fifo_ser;

    localparam int CLK_DIV = 4;

    logic        wclk = 1'b0;
    logic        rst = 1'b1;
    logic        wen = 1'b0;
    logic [31:0] din = '0;
    logic        enable = 1'b0;
    logic        master = 1'b1;
    logic        stereo = 1'b1;
    logic [1:0]  standard = 2'b01;
    logic        frame_size = 1'b0;
    logic        sck_i = 1'b1;
    logic        ws_i = 1'b1;
    logic        underrun_clr = 1'b0;
    logic        sck_o, ws_o, sd_o, full, empty, underrun, overflow;
    logic [3:0]  level;
    logic [15:0] underrun_cnt;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    logic cap_sd [256];
    logic cap_ws [256];
    int   cap_cyc [256];
    logic first_sd;

    i2s_tx_fifo_ser dut (
        .wclk(wclk), .rst(rst), .wen(wen), .din(din), .enable(enable),
        .master(master), .stereo(stereo), .standard(standard),
        .frame_size(frame_size), .sck_i(sck_i), .ws_i(ws_i),
        .underrun_clr(underrun_clr), .sck_o(sck_o), .ws_o(ws_o), .sd_o(sd_o),
        .full(full), .empty(empty), .level(level), .underrun(underrun),
        .overflow(overflow), .underrun_cnt(underrun_cnt)
    );

    always #5 wclk = ~wclk;
    always @(posedge wclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [31:0] w);
        @(negedge wclk);
        wen = 1'b1;
        din = w;
        @(negedge wclk);
        wen = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge wclk);
        rst = 1'b1;
        @(negedge wclk);
        rst = 1'b0;
    endtask

    // Records sd_o/ws_o at each sck_o rise, the point a receiver samples.
    task automatic capture(input int nbits, input int drop_at, output int got);
        int   budget;
        logic prev;
        got    = 0;
        budget = 0;
        prev   = sck_o;
        while (got < nbits && budget < nbits * 2 * CLK_DIV + 40) begin
            @(negedge wclk);
            budget++;
            if (budget == 1) first_sd = sd_o;
            if (sck_o && !prev) begin
                cap_sd[got]  = sd_o;
                cap_ws[got]  = ws_o;
                cap_cyc[got] = cyc;
                got++;
                if (got == drop_at) enable = 1'b0;
            end
            prev = sck_o;
        end
    endtask

    // Master-mode frames checked against a bit stream built from the words.
    task automatic run_case(input string tag, input int nfr, input bit st, input bit fsz,
                            input logic [1:0] std, input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3);
        logic [31:0] w [4];
        bit          lj [$];
        logic [31:0] lw, rw;
        int          s, nw, n, got, c0;
        bit          phil, exp_sd;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        s    = fsz ? 32 : 16;
        phil = (std != 2'b01);
        nw   = st ? 2 * nfr : nfr;
        lj.delete();
        for (int f = 0; f < nfr; f++) begin
            lw = st ? w[2*f] : w[f];
            rw = st ? w[2*f+1] : w[f];
            for (int k = 0; k < s; k++) lj.push_back(lw[s-1-k]);
            for (int k = 0; k < s; k++) lj.push_back(rw[s-1-k]);
        end
        for (int i = 0; i < nw; i++) write_word(w[i]);
        chk({tag, " level_before"}, 32'(level), 32'(nw));
        master     = 1'b1;
        stereo     = st;
        frame_size = fsz;
        standard   = std;
        n          = nfr * 2 * s;
        @(negedge wclk);
        enable = 1'b1;
        c0     = cyc + 1;
        capture(n, (nfr - 1) * 2 * s + 1, got);
        chk({tag, " bit_count"}, 32'(got), 32'(n));
        chk({tag, " first_bit"}, 32'(first_sd), 32'(phil ? 1'b0 : lj[0]));
        if (got >= 2) begin
            chk({tag, " sck_rise_latency"}, 32'(cap_cyc[0] - c0), 32'(CLK_DIV));
            chk({tag, " sck_period"}, 32'(cap_cyc[1] - cap_cyc[0]), 32'(2 * CLK_DIV));
        end
        for (int p = 0; p < got; p++) begin
            exp_sd = phil ? ((p == 0) ? 1'b0 : lj[p-1]) : lj[p];
            chk($sformatf("%s sd[%0d]", tag, p), 32'(cap_sd[p]), 32'(exp_sd));
            chk($sformatf("%s ws[%0d]", tag, p), 32'(cap_ws[p]), 32'((p / s) % 2));
        end
        repeat (3 * CLK_DIV) @(negedge wclk);
        chk({tag, " level_after"}, 32'(level), 32'd0);
        chk({tag, " idle_lines"}, {29'd0, sck_o, ws_o, sd_o}, 32'd0);
        enable = 1'b0;
    endtask

    task automatic slave_bit(input logic ws, output logic sd, output logic wso);
        @(negedge wclk);
        sck_i = 1'b0;
        ws_i  = ws;
        repeat (4) @(negedge wclk);
        sd    = sd_o;
        wso   = ws_o;
        sck_i = 1'b1;
        repeat (3) @(negedge wclk);
    endtask

    initial begin
        int          got, nfr, exp_cnt;
        bit          st, fsz;
        logic [1:0]  std;
        logic        sd, wso, exp_bit;
        logic [31:0] sw;

        repeat (3) @(negedge wclk);
        rst = 1'b0;
        @(negedge wclk);
        chk("reset empty", 32'(empty), 32'd1);
        chk("reset full", 32'(full), 32'd0);
        chk("reset level", 32'(level), 32'd0);
        chk("reset lines", {29'd0, sck_o, ws_o, sd_o}, 32'd0);
        chk("reset flags", {30'd0, underrun, overflow}, 32'd0);
        chk("reset cnt", 32'(underrun_cnt), 32'd0);

        run_case("lj_dir", 1, 1'b1, 1'b0, 2'b01, 32'h0000A5A5, 32'h00003C3C, 0, 0);
        run_case("ph_dir", 1, 1'b1, 1'b0, 2'b00, 32'h0000A5A5, 32'h00003C3C, 0, 0);

        for (int r = 0; r < 6; r++) begin
            std = 2'($urandom_range(0, 3));
            fsz = 1'($urandom_range(0, 1));
            st  = 1'($urandom_range(0, 1));
            nfr = $urandom_range(1, 2);
            run_case($sformatf("rnd%0d", r), nfr, st, fsz, std,
                     $urandom, $urandom, $urandom, $urandom);
        end
        chk("no_underrun", 32'(underrun), 32'd0);

        // Overflow: nine back-to-back writes into an eight-deep FIFO.
        do_reset();
        @(negedge wclk);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                chk("pre_full full", 32'(full), 32'd0);
                chk("pre_full level", 32'(level), 32'd7);
            end
            wen = 1'b1;
            din = 32'(i);
            @(negedge wclk);
        end
        chk("full after 8", 32'(full), 32'd1);
        chk("level after 8", 32'(level), 32'd8);
        chk("ovf before 9th", 32'(overflow), 32'd0);
        din = 32'h99;
        @(negedge wclk);
        wen = 1'b0;
        chk("ovf after 9th", 32'(overflow), 32'd1);
        chk("level after 9th", 32'(level), 32'd8);
        underrun_clr = 1'b1;
        @(negedge wclk);
        underrun_clr = 1'b0;
        chk("ovf cleared", 32'(overflow), 32'd0);

        // Underrun: stereo frame with only one word queued.
        do_reset();
        write_word(32'h0000FFFF);
        master = 1'b1; stereo = 1'b1; frame_size = 1'b0; standard = 2'b01;
        @(negedge wclk);
        enable = 1'b1;
        capture(32, 1, got);
        chk("udr bit_count", 32'(got), 32'd32);
        for (int p = 0; p < got; p++) begin
            chk($sformatf("udr sd[%0d]", p), 32'(cap_sd[p]), 32'd0);
            chk($sformatf("udr ws[%0d]", p), 32'(cap_ws[p]), 32'((p / 16) % 2));
        end
        repeat (2 * CLK_DIV) @(negedge wclk);
        chk("udr level", 32'(level), 32'd1);
        chk("udr flag", 32'(underrun), 32'd1);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        exp_cnt = 1;
`else
        exp_cnt = 0;
`endif
        chk("udr cnt", 32'(underrun_cnt), 32'(exp_cnt));
        underrun_clr = 1'b1;
        @(negedge wclk);
        underrun_clr = 1'b0;
        chk("udr cleared", 32'(underrun), 32'd0);

        // Slave, Philips, 32-bit slots, mono.
        do_reset();
        sw = 32'h80000001;
        write_word(sw);
        master = 1'b0; stereo = 1'b0; frame_size = 1'b1; standard = 2'b00;
        enable = 1'b1;
        for (int j = 0; j < 3; j++) slave_bit(1'b1, sd, wso);
        chk("slv idle sd", 32'(sd), 32'd0);
        for (int j = 0; j < 65; j++) begin
            slave_bit((j < 32 || j >= 64) ? 1'b0 : 1'b1, sd, wso);
            // Philips stream: delay bit, then the word once per slot.
            exp_bit = (j == 0) ? 1'b0 : sw[31 - ((j - 1) % 32)];
            chk($sformatf("slv sd[%0d]", j), 32'(sd), 32'(exp_bit));
            chk($sformatf("slv ws[%0d]", j), 32'(wso), 32'((j / 32) % 2));
        end
        enable = 1'b0;
        chk("slv level", 32'(level), 32'd0);

        // Reset in the middle of a slot.
        do_reset();
        write_word(32'h0000FFFF);
        write_word(32'h0000FFFF);
        master = 1'b1; stereo = 1'b1; frame_size = 1'b0; standard = 2'b01;
        @(negedge wclk);
        enable = 1'b1;
        repeat (20) @(negedge wclk);
        chk("mid sd before rst", 32'(sd_o), 32'd1);
        rst = 1'b1;
        @(negedge wclk);
        chk("mid rst lines", {29'd0, sck_o, ws_o, sd_o}, 32'd0);
        chk("mid rst empty", 32'(empty), 32'd1);
        chk("mid rst level", 32'(level), 32'd0);
        rst    = 1'b0;
        enable = 1'b0;
        @(negedge wclk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2s_tx_fifo_ser.md
Name: i2s_tx_fifo_ser

Overview:
Parametrised I2S transmit FIFO plus serialiser and the next generation of the codebase's TX FIFO. All logic runs in the wclk domain. Master mode generates sck/ws internally from a divider. Slave mode oversamples external sck/ws through 2-flop synchronisers. Adds programmable depth and width, Philips and left-justified framing, frame-aligned stereo popping, mono duplication, underrun zero-fill and sticky error flags.

Parameters:
DATA_W, 32, FIFO word width; even, >=8; slot length is DATA_W/2 or DATA_W bits
DEPTH, 8, FIFO depth in words; power of 2, >=2
CLK_DIV, 4, master mode: wclk cycles per sck half-period; >=2

Ports:
wclk  in  1  system and write clock; all state on rising edge
rst  in  1  reset, synchronous, active-high
wen  in  1  write request
din  in  DATA_W  sample word; active bits are LSB-aligned to the slot
enable  in  1  transmit enable
master  in  1  1 = master (drive sck_o/ws_o), 0 = slave
stereo  in  1  1 = two words per frame (L then R), 0 = mono
standard  in  2  00 Philips I2S, 01 left-justified, 1x reserved (treated as Philips)
frame_size  in  1  0 = slot DATA_W/2 bits, 1 = slot DATA_W bits
sck_i  in  1  slave bit clock, async, frequency <= f(wclk)/4
ws_i  in  1  slave word select, async
underrun_clr  in  1  clears underrun and overflow
sck_o  out  1  master bit clock
ws_o  out  1  word select; 0 = left, 1 = right
sd_o  out  1  serial data, MSB first
full  out  1  level == DEPTH
empty  out  1  level == 0
level  out  $clog2(DEPTH)+1  words stored
underrun  out  1  sticky: a frame was zero-filled
overflow  out  1  sticky: a write was dropped while full
underrun_cnt  out  16  underrun frame count (optional feature)

Behaviour:
- Reset: FIFO pointers 0, level 0, empty=1, full=0, sck_o=0, ws_o=0, sd_o=0, underrun=0, overflow=0, underrun_cnt=0, serialiser IDLE, divider 0.
- Write path:
  - wen && !full stores din at the write pointer and increments the pointer (wraps modulo DEPTH) and level.
  - wen && full drops the word and sets overflow.
  - full/empty/level are registered and update the cycle after a write or pop.
  - A write and a pop in the same cycle leave level unchanged. A write while full is dropped even if a pop occurs in that cycle.
- Shift event:
  - Master: divider counts 0..CLK_DIV-1; sck_o toggles at terminal count; a shift event is the cycle sck_o goes 1->0.
  - Slave: a shift event is a detected 1->0 edge on the synchronised sck_i.
  - sd_o and ws_o update only on shift events and are held otherwise.
- Frame fetch, at left-slot start:
  - Stereo: requires level>=2. Pops two words in one cycle; word0 goes to the shift register, word1 to a hold register for the right slot.
  - Mono: requires level>=1. Pops one word, sent in both slots.
  - If the required level is not met: no pop, both slots send zeros, underrun set. This guarantees L/R word-pair alignment.
- Bit order: with S = slot bits, bit k of a slot (k=0..S-1) carries word bit S-1-k.
- ws timing:
  - Left-justified: ws_o changes on the same shift event as the slot's MSB.
  - Philips: ws_o changes one shift event before the MSB. The previous slot's LSB is sent with the new ws.
- Serialiser states:
  - IDLE -> RUN when enable=1 at a frame boundary.
  - RUN: bit counter 0..S-1, channel bit toggles at S-1.
  - RUN -> IDLE at the end of the right slot if enable=0. Disabling mid-frame completes the frame.
  - IDLE drives sck_o=0, ws_o=0, sd_o=0.
- Master start latency: the first left-slot bit (or the Philips delay bit, 0) appears 1 cycle after enable is sampled high; the first sck_o rise follows CLK_DIV cycles later.
- Slave alignment:
  - A frame starts at a synchronised ws_i 1->0 edge: on that shift event for LJ, on the next shift event for Philips.
  - Before the first ws_i falling edge the block stays in IDLE.
  - A ws_i edge arriving at an unexpected bit position resynchronises the bit counter and sets underrun for that frame.
- frame_size, stereo, standard and master are sampled only at frame boundaries in IDLE/RUN.
- underrun_clr clears both sticky flags. If a new error occurs in the same cycle, the set wins.
- rst mid-frame: immediate return to reset state; FIFO contents are discarded.

Optional Feature:
- Macro: I2S_TX_UNDERRUN_CNT_EN.
- With the macro defined: underrun_cnt is a 16-bit saturating counter, +1 per zero-filled frame, held at 16'hFFFF, cleared by rst only.
- Without it: underrun_cnt is tied to 0 and no counter logic exists.

Test Plan:
- Master, LJ, stereo, frame_size=0, CLK_DIV=4; write 32'h0000A5A5, 32'h00003C3C, then enable -> ws_o=0 for bits A5A5 MSB-first, ws_o=1 for 3C3C; sck period 8 wclk; level goes 2->0.
- Same stimulus with standard=00 -> ws_o leads the MSB by exactly one shift event; the first bit after enable is 0.
- Write 9 words with DEPTH=8 -> full=1 after the 8th write, 9th write dropped, overflow=1, level=8; underrun_clr -> overflow=0.
- Stereo with only 1 word queued at frame start -> both slots all zeros, underrun=1, level stays 1 (no pop); counter=1 if the macro is defined.
- Slave, Philips, frame_size=1, sck_i = wclk/8; write 32'h80000001 (mono) -> the same word appears in the L and R slots, each aligned one sck after the ws_i edge.
- Assert rst mid-slot -> next cycle sd_o=0, ws_o=0, sck_o=0, empty=1, level=0.
